// File: rtl/cordic_phase_frontend.sv
// rtl/cordic_phase_frontend.sv - phase folding, rotator sequencing and quadrant correction for the CORDIC rotator
module cordic_phase_frontend #(
    parameter int DW      = 16,
    parameter int PIHALF  = 25736,
    parameter int TIMEOUT = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] phase_in,
    output logic          cordic_en,
    output logic [DW-1:0] cordic_z,
    input  logic          cordic_done,
    input  logic [DW-1:0] cordic_x,
    input  logic [DW-1:0] cordic_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] cos_out,
    output logic [DW-1:0] sin_out,
    output logic          timeout_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [DW-1:0] PIH = DW'(PIHALF);
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

    logic [1:0]    r_state;
    logic [1:0]    r_q;
    logic [DW-1:0] r_z;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_cos;
    logic [DW-1:0] r_sin;
    logic          r_tout;

    logic [1:0]    w_q;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_cos;
    logic [DW-1:0] w_sin;

    // Binary angle to radians Q2.14: arithmetic shift of the full-width product
    function automatic logic [DW-1:0] scale_z(input logic signed [DW-1:0] r);
        logic signed [2*DW-1:0] p;
        p = (2*DW)'(r) * (2*DW)'(PIH);
        p = p >>> (DW - 2);
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    // Rounding to the nearest quadrant: adding pi/4 carries only into the top two bits
    assign w_q = phase_in[DW-1:DW-2] + {1'b0, phase_in[DW-3]};
    assign w_r = phase_in - {w_q, {(DW-2){1'b0}}};

    always_comb begin
        w_cos = cordic_x;
        w_sin = cordic_y;
        case (r_q)
            2'd1: begin
                w_cos = neg_sat(cordic_y);
                w_sin = cordic_x;
            end
            2'd2: begin
                w_cos = neg_sat(cordic_x);
                w_sin = neg_sat(cordic_y);
            end
            2'd3: begin
                w_cos = cordic_y;
                w_sin = neg_sat(cordic_x);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= 2'd0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_tout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q     <= w_q;
                        r_z     <= scale_z($signed(w_r));
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        r_cos   <= w_cos;
                        r_sin   <= w_sin;
                        r_state <= HOLD;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_tout  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign cordic_en   = (r_state == LAUNCH);
    assign out_valid   = (r_state == HOLD);
    assign cordic_z    = r_z;
    assign cos_out     = r_cos;
    assign sin_out     = r_sin;
    assign timeout_err = r_tout;

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// tb/tb_cordic_phase_frontend.sv - randomized self-checking bench for cordic_phase_frontend
module tb_cordic_phase_frontend;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] phase_in = 16'h0;
    logic        cordic_en;
    logic [15:0] cordic_z;
    logic        cordic_done;
    logic [15:0] cordic_x;
    logic [15:0] cordic_y;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] cos_out;
    logic [15:0] sin_out;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic        rot_on = 1'b1;
    logic        sat = 1'b0;
    logic        inj_done = 1'b0;
    logic        rot_done;
    int          rcnt;
    logic [31:0] garb;

    cordic_phase_frontend dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .phase_in(phase_in),
        .cordic_en(cordic_en), .cordic_z(cordic_z), .cordic_done(cordic_done),
        .cordic_x(cordic_x), .cordic_y(cordic_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .cos_out(cos_out), .sin_out(sin_out), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Rotator model: ideal cos/sin of the residual angle, garbage outside the done pulse
    always @(posedge clk or posedge rst) begin
        if (rst) rcnt <= 0;
        else if (cordic_en && rot_on) rcnt <= 17;
        else if (rcnt != 0) rcnt <= rcnt - 1;
    end
    always @(posedge clk) garb <= $urandom;

    assign rot_done    = (rcnt == 1);
    assign cordic_done = rot_done | inj_done;

    always_comb begin
        cordic_x = garb[15:0];
        cordic_y = garb[31:16];
        if (rot_done) begin
            if (sat) begin
                cordic_x = 16'h8000;
                cordic_y = 16'h8000;
            end else begin
                cordic_x = 16'(rnd(16384.0 * $cos(real'($signed(cordic_z)) / 16384.0)));
                cordic_y = 16'(rnd(16384.0 * $sin(real'($signed(cordic_z)) / 16384.0)));
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int d;
        n_chk++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int ref_cos(input logic [15:0] ph);
        return rnd(16384.0 * $cos(2.0 * PI * real'(ph) / 65536.0));
    endfunction

    function automatic int ref_sin(input logic [15:0] ph);
        return rnd(16384.0 * $sin(2.0 * PI * real'(ph) / 65536.0));
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", int'(in_ready), 1, 0);
    endtask

    task automatic run(input logic [15:0] ph, input int hold, input int ec, input int es, input int tol);
        int n;
        int r;
        int ez;
        logic [15:0] hc;
        logic [15:0] hs;
        r  = ((int'(ph) + 8192) % 16384) - 8192;
        ez = int'($floor(real'(r) * 25736.0 / 16384.0));
        wait_ready();
        in_valid = 1'b1;
        phase_in = ph;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("launch_en", int'(cordic_en), 1, 0);
        check("cordic_z", int'($signed(cordic_z)), ez, 0);
        check("busy_in_ready", int'(in_ready), 0, 0);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) check("en_one_cycle", int'(cordic_en), 0, 0);
            if (out_valid) break;
        end
        check("latency", n, 18, 0);
        check("cos", int'($signed(cos_out)), ec, tol);
        check("sin", int'($signed(sin_out)), es, tol);
        hc = cos_out;
        hs = sin_out;
        in_valid = 1'b1;
        phase_in = 16'($urandom);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1, 0);
            check("hold_cos", int'(cos_out), int'(hc), 0);
            check("hold_sin", int'(sin_out), int'(hs), 0);
            check("hold_in_ready", int'(in_ready), 0, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drop_valid", int'(out_valid), 0, 0);
        check("idle_ready", int'(in_ready), 1, 0);
    endtask

    initial begin
        logic [15:0] dir [9];
        logic [15:0] ph;
        int n;
        int tedge;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_en", int'(cordic_en), 0, 0);
        check("rst_z", int'(cordic_z), 0, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_cos", int'(cos_out), 0, 0);
        check("rst_sin", int'(sin_out), 0, 0);
        check("rst_tout", int'(timeout_err), 0, 0);
        rst = 1'b0;

        dir = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hE000,
                16'h1000, 16'h2000, 16'hFFFF, 16'hDFFF};
        foreach (dir[i]) run(dir[i], (i == 0) ? 10 : 1, ref_cos(dir[i]), ref_sin(dir[i]), 8);

        sat = 1'b1;
        run(16'h8000, 0, 32767, 32767, 0);
        sat = 1'b0;

        for (int i = 0; i < 20; i++) begin
            ph = 16'($urandom);
            run(ph, $urandom_range(0, 3), ref_cos(ph), ref_sin(ph), 8);
        end

        rot_on = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        phase_in = 16'h1234;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        seen = 0;
        tedge = -1;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) seen = 1;
            if (timeout_err && tedge < 0) tedge = n;
        end
        check("timeout_edge", tedge, 32, 0);
        check("timeout_no_valid", seen, 0, 0);
        check("timeout_ready", int'(in_ready), 1, 0);
        rot_on = 1'b1;
        run(16'h1000, 1, ref_cos(16'h1000), ref_sin(16'h1000), 8);
        check("tout_sticky", int'(timeout_err), 1, 0);

        wait_ready();
        in_valid = 1'b1;
        phase_in = 16'h4000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1, 0);
        check("mid_rst_en", int'(cordic_en), 0, 0);
        check("mid_rst_z", int'(cordic_z), 0, 0);
        check("mid_rst_valid", int'(out_valid), 0, 0);
        check("mid_rst_cos", int'(cos_out), 0, 0);
        check("mid_rst_tout", int'(timeout_err), 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1;
        end
        check("spurious_done_ignored", seen, 0, 0);

        run(16'hC000, 2, ref_cos(16'hC000), ref_sin(16'hC000), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
